// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// This is the registered writeback stage between the memory stage and the
// register file. It takes one retiring instruction per cycle over a
// valid/ready handshake. ALU results and link (PC+4) results are written one
// cycle after acceptance. A load parks the stage in WAIT_MEM until the memory
// read response arrives. The stage then size-selects the response,
// zero- or sign-extends it, and writes it. Writes to ZERO_REG are suppressed.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/ready   upstream handshake (ready = stage idle)
//   alu_result       ALU result            (mem_to_reg = 0)
//   incremented_pc   PC+4 for link writes  (mem_to_reg = 2)
//   mem_to_reg       0=ALU, 1=load, 2=PC+4, 3=reserved
//   load_size        0=byte, 1=half, 2=word, 3=dword
//   load_signed      sign-extend load data
//   reg_write, rd    write request and destination register
//   mem_rvalid/rdata memory read response (single-cycle pulse)
//   rf_we/waddr/wdata registered register-file write port
//   busy             waiting on a load response
//   illegal          one-cycle pulse after a reserved mem_to_reg is accepted
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int WORD       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD-1:0]       alu_result,
  input  logic [WORD-1:0]       incremented_pc,
  input  logic [1:0]            mem_to_reg,
  input  logic [1:0]            load_size,
  input  logic                  load_signed,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_rvalid,
  input  logic [WORD-1:0]       mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD-1:0]       rf_wdata,
  output logic                  busy,
  output logic                  illegal
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_LOAD = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  logic [0:0]            state_reg;
  logic                  ld_reg_write_reg;
  logic [REG_ADDR_W-1:0] ld_rd_reg;
  logic [1:0]            ld_size_reg;
  logic                  ld_signed_reg;

  logic                  rf_we_reg;
  logic [REG_ADDR_W-1:0] rf_waddr_reg;
  logic [WORD-1:0]       rf_wdata_reg;
  logic                  illegal_reg;

  logic                  accept;
  logic [WORD-1:0]       load_ext;
  logic [WORD-1:0]       word_ext;

  // Ready depends only on the state register. This keeps the handshake free
  // of combinational paths from in_valid.
  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg == WAIT_MEM);
  assign accept   = in_valid && in_ready;

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign illegal  = illegal_reg;

  // A 32-bit word load only needs extending on a 64-bit datapath. On a
  // 32-bit datapath it is already the full word.
  generate
    if (WORD > 32) begin : g_word_wide
      assign word_ext = {{(WORD-32){ld_signed_reg & mem_rdata[31]}}, mem_rdata[31:0]};
    end else begin : g_word_narrow
      assign word_ext = mem_rdata;
    end
  endgenerate

  always_comb begin
    load_ext = mem_rdata;
    case (ld_size_reg)
      2'd0:    load_ext = {{(WORD-8){ld_signed_reg & mem_rdata[7]}}, mem_rdata[7:0]};
      2'd1:    load_ext = {{(WORD-16){ld_signed_reg & mem_rdata[15]}}, mem_rdata[15:0]};
      2'd2:    load_ext = word_ext;
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      ld_reg_write_reg <= 1'b0;
      ld_rd_reg        <= '0;
      ld_size_reg      <= 2'd0;
      ld_signed_reg    <= 1'b0;
      rf_we_reg        <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
      illegal_reg      <= 1'b0;
    end else begin
      // Both the write enable and the illegal flag are single-cycle pulses.
      rf_we_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            case (mem_to_reg)
              SRC_ALU, SRC_LINK: begin
                rf_we_reg    <= reg_write && (rd != ZERO_IDX);
                rf_waddr_reg <= rd;
                rf_wdata_reg <= (mem_to_reg == SRC_LINK) ? incremented_pc : alu_result;
              end
              SRC_LOAD: begin
                ld_reg_write_reg <= reg_write;
                ld_rd_reg        <= rd;
                ld_size_reg      <= load_size;
                ld_signed_reg    <= load_signed;
                state_reg        <= WAIT_MEM;
              end
              default: begin
                illegal_reg <= 1'b1;
              end
            endcase
          end
          // A mem_rvalid seen here is a stale response and is ignored.
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            rf_we_reg    <= ld_reg_write_reg && (ld_rd_reg != ZERO_IDX);
            rf_waddr_reg <= ld_rd_reg;
            rf_wdata_reg <= load_ext;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with WORD=64.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [63:0] incremented_pc;
  logic [1:0]  mem_to_reg;
  logic [1:0]  load_size;
  logic        load_signed;
  logic        reg_write;
  logic [4:0]  rd;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        busy;
  logic        illegal;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  writeback_stage #(.WORD(64), .REG_ADDR_W(5), .ZERO_REG(31)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .incremented_pc (incremented_pc),
    .mem_to_reg     (mem_to_reg),
    .load_size      (load_size),
    .load_signed    (load_signed),
    .reg_write      (reg_write),
    .rd             (rd),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .busy           (busy),
    .illegal        (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] m2r, input logic rw, input logic [4:0] dst,
                       input logic [63:0] alu, input logic [63:0] pc,
                       input logic [1:0] sz, input logic sgn);
    in_valid       = 1'b1;
    mem_to_reg     = m2r;
    reg_write      = rw;
    rd             = dst;
    alu_result     = alu;
    incremented_pc = pc;
    load_size      = sz;
    load_signed    = sgn;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [63:0] data);
    chk({tag, ".we"}, 64'(rf_we), 64'(we));
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(addr));
    chk({tag, ".wdata"}, rf_wdata, data);
  endtask

  // Accept a load, hold ready low for lat cycles, then return the response.
  task automatic do_load(input string tag, input logic rw, input logic [4:0] dst,
                         input logic [1:0] sz, input logic sgn, input int lat,
                         input logic [63:0] data, input logic exp_we,
                         input logic [63:0] exp_data);
    drive(2'd1, rw, dst, 64'hDEAD, 64'hBEEF, sz, sgn);
    step();
    in_valid = 1'b0;
    chk({tag, ".we_accept"}, 64'(rf_we), 64'd0);
    for (int i = 0; i < lat - 1; i++) begin
      chk({tag, ".ready_wait"}, 64'(in_ready), 64'd0);
      chk({tag, ".busy_wait"}, 64'(busy), 64'd1);
      step();
    end
    chk({tag, ".ready_wait"}, 64'(in_ready), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h5555_5555_5555_5555;
    chk_wr(tag, exp_we, dst, exp_data);
    chk({tag, ".ready_done"}, 64'(in_ready), 64'd1);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    step();
    chk({tag, ".we_after"}, 64'(rf_we), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    alu_result     = '0;
    incremented_pc = '0;
    mem_to_reg     = 2'd0;
    load_size      = 2'd0;
    load_signed    = 1'b0;
    reg_write      = 1'b0;
    rd             = '0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;

    // Reset state
    step();
    step();
    chk_wr("reset", 1'b0, 5'd0, 64'd0);
    chk("reset.illegal", 64'(illegal), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    reset = 1'b0;
    chk("reset.ready", 64'(in_ready), 64'd1);

    // Back-to-back ALU writes
    drive(2'd0, 1'b1, 5'd3, 64'h10, 64'h0, 2'd0, 1'b0);
    step();
    chk_wr("alu0", 1'b1, 5'd3, 64'h10);
    chk("alu0.ready", 64'(in_ready), 64'd1);
    drive(2'd0, 1'b1, 5'd4, 64'h20, 64'h0, 2'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk_wr("alu1", 1'b1, 5'd4, 64'h20);
    chk("alu1.ready", 64'(in_ready), 64'd1);
    step();
    chk_wr("alu_idle", 1'b0, 5'd4, 64'h20);

    // Link write
    drive(2'd2, 1'b1, 5'd30, 64'h7777, 64'h1004, 2'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk_wr("link", 1'b1, 5'd30, 64'h1004);

    // Loads of each size
    do_load("lb_s", 1'b1, 5'd5, 2'd0, 1'b1, 3, 64'h1234_5678_9ABC_DE80, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lb_u", 1'b1, 5'd5, 2'd0, 1'b0, 3, 64'h1234_5678_9ABC_DE80, 1'b1, 64'h0000_0000_0000_0080);
    do_load("lh_s", 1'b1, 5'd6, 2'd1, 1'b1, 2, 64'hAAAA_BBBB_1234_8001, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lh_u", 1'b1, 5'd6, 2'd1, 1'b0, 1, 64'hAAAA_BBBB_1234_8001, 1'b1, 64'h0000_0000_0000_8001);
    do_load("lw_s", 1'b1, 5'd7, 2'd2, 1'b1, 2, 64'h1111_2222_8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000);
    do_load("lw_u", 1'b1, 5'd7, 2'd2, 1'b0, 1, 64'h1111_2222_8000_0000, 1'b1, 64'h0000_0000_8000_0000);
    do_load("ld",   1'b1, 5'd8, 2'd3, 1'b1, 2, 64'h8765_4321_0FED_CBA9, 1'b1, 64'h8765_4321_0FED_CBA9);

    // Suppressed writes
    drive(2'd0, 1'b1, 5'd31, 64'hABCD, 64'h0, 2'd0, 1'b0);
    step();
    chk_wr("xzr", 1'b0, 5'd31, 64'hABCD);
    chk("xzr.ready", 64'(in_ready), 64'd1);
    drive(2'd0, 1'b0, 5'd12, 64'h4321, 64'h0, 2'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk_wr("norw", 1'b0, 5'd12, 64'h4321);
    do_load("ld_xzr", 1'b1, 5'd31, 2'd3, 1'b0, 2, 64'hCAFE, 1'b0, 64'hCAFE);
    do_load("ld_norw", 1'b0, 5'd9, 2'd0, 1'b0, 1, 64'h00F1, 1'b0, 64'h00F1);

    // Reserved mem_to_reg
    drive(2'd3, 1'b1, 5'd10, 64'h99, 64'h0, 2'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ill.pulse", 64'(illegal), 64'd1);
    chk("ill.we", 64'(rf_we), 64'd0);
    chk("ill.ready", 64'(in_ready), 64'd1);
    step();
    chk("ill.clear", 64'(illegal), 64'd0);

    // Reset during WAIT_MEM, then a stale response
    drive(2'd1, 1'b1, 5'd11, 64'h0, 64'h0, 2'd3, 1'b0);
    step();
    in_valid = 1'b0;
    chk("abort.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort.busy_rst", 64'(busy), 64'd0);
    chk_wr("abort.rst", 1'b0, 5'd0, 64'd0);
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFF;
    step();
    mem_rvalid = 1'b0;
    chk_wr("stale", 1'b0, 5'd0, 64'd0);
    chk("stale.busy", 64'(busy), 64'd0);
    drive(2'd0, 1'b1, 5'd9, 64'h99, 64'h0, 2'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk_wr("post_abort", 1'b1, 5'd9, 64'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered, handshaked successor to the combinational writeback mux. It sits between the memory stage and the register file.
- Accepts one retiring instruction per cycle over valid/ready.
- Loads wait for a variable-latency memory read response. Load data is size-selected and zero- or sign-extended, parametrised in datapath width.
- Issues a single-cycle registered register-file write and suppresses writes to the zero register.

Parameters:
- WORD, 64, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register address width.
- ZERO_REG, 31, register index whose writes are suppressed (XZR).

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; handshake when in_valid && in_ready
- alu_result  in  WORD  ALU result
- incremented_pc  in  WORD  PC+4, used for link writes
- mem_to_reg  in  2  0=ALU, 1=load, 2=PC+4, 3=reserved
- load_size  in  2  0=byte, 1=half, 2=word(32), 3=dword
- load_signed  in  1  1 = sign-extend load data
- reg_write  in  1  instruction writes rd
- rd  in  REG_ADDR_W  destination register
- mem_rvalid  in  1  read data valid, one-cycle pulse
- mem_rdata  in  WORD  read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  WORD  write data
- busy  out  1  state != IDLE
- illegal  out  1  pulse: reserved mem_to_reg was accepted

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, illegal=0, busy=0. in_ready=1 once reset deasserts.
- Two states, IDLE and WAIT_MEM. in_ready = (state==IDLE), a combinational decode of the state register only.
- IDLE, handshake with mem_to_reg in {0,2}:
  - Result is alu_result or incremented_pc.
  - Next edge: rf_we = reg_write && (rd != ZERO_REG), rf_waddr=rd, rf_wdata=result.
  - State stays IDLE. Throughput is 1 per cycle and latency is 1 cycle.
- IDLE, handshake with mem_to_reg==1:
  - Capture reg_write, rd, load_size, load_signed; state goes to WAIT_MEM.
  - rf_we=0 on the next cycle.
- WAIT_MEM:
  - Wait for mem_rvalid. On the cycle mem_rvalid=1, next edge: extended data is written under the same rf_we rule; state goes to IDLE.
  - in_ready is therefore high again in the same cycle rf_we is high.
  - Load latency = memory latency + 1.
  - No timeout; WAIT_MEM holds indefinitely.
- mem_rvalid in IDLE is ignored; this covers stale responses.
- mem_to_reg==3 accepted: no write (rf_we=0); illegal=1 for exactly the next cycle; state stays IDLE.
- Load extension, where k = 8/16/32 for size 0/1/2:
  - Take mem_rdata[k-1:0]; fill the upper WORD-k bits with 0, or with bit k-1 when load_signed.
  - Size 3: mem_rdata unchanged, load_signed ignored.
  - WORD=32: sizes 2 and 3 both pass the full word unchanged.
- rf_we is high for exactly one cycle per writing instruction.
- rf_waddr and rf_wdata update on every completed transaction, including suppressed ones, and hold between transactions.
- Reset asserted in WAIT_MEM: the load is aborted, no write occurs, and the state returns to IDLE.
- in_valid while busy: not accepted; the upstream stage holds it. Inputs are sampled only at the handshake; mem_rdata is sampled only on mem_rvalid in WAIT_MEM.

Test Plan:
- Reset, then back-to-back ALU writes: rd=3 alu=0x10, then rd=4 alu=0x20 → rf_we high two consecutive cycles, (3,0x10) then (4,0x20); in_ready constant 1.
- Link write, rd=30: mem_to_reg=2, incremented_pc=0x1004 → one cycle later rf_we=1, waddr=30, wdata=0x1004.
- Signed byte load, rd=5, mem_rvalid 3 cycles after accept:
  - mem_rdata=0x...80 → wdata=0xFFFFFFFFFFFFFF80.
  - Repeat unsigned → 0x80.
  - in_ready low for 3 cycles.
- Half load, signed, data 0x1234_8001 → 0xFFFFFFFFFFFF8001. Word load, signed, data 0x8000_0000 → 0xFFFFFFFF80000000. Dword → data unchanged.
- Write to rd=31, plus reg_write=0 case → rf_we stays 0, busy/ready sequence unchanged. mem_to_reg=3 → illegal pulses one cycle, no write.
- Reset asserted mid WAIT_MEM, then a stale mem_rvalid pulse in IDLE → no rf_we, outputs zero, next ALU instruction writes normally.
